// File: rtl/alu_conv_pkg.sv
// rtl/alu_conv_pkg.sv - opcode encodings and shift-amount width helper for alu_conv_pipe
package alu_conv_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_PAS = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  // Never narrower than one bit so WIDTH=2 still gets a usable shift field.
  function automatic int shamt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/alu_conv_core.sv
// rtl/alu_conv_core.sv - combinational ALU datapath; saturating ADD/SUB when ALU_CONV_PIPE_SAT_EN is defined
module alu_conv_core
  import alu_conv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int SHW = shamt_w(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    shamt  = b[SHW-1:0];
    result = '0;
    carry  = 1'b0;
    case (ctrl)
      OP_ADD: begin
        carry = sum[WIDTH];
`ifdef ALU_CONV_PIPE_SAT_EN
        result = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        result = sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        // The extra MSB of the widened difference is the borrow out.
        carry = diff[WIDTH];
`ifdef ALU_CONV_PIPE_SAT_EN
        result = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        result = diff[WIDTH-1:0];
`endif
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_PAS:  result = a;
      OP_SHL:  result = a << shamt;
      OP_SHR:  result = a >> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_conv_pipe.sv
// rtl/alu_conv_pipe.sv - two-stage valid/ready ALU pipeline with operand-A mux and accumulator
// Optional saturation feature: ALU_CONV_PIPE_SAT_EN (implemented in alu_conv_core).
module alu_conv_pipe
  import alu_conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NUM_A = 2,
  parameter int SEL_W = (NUM_A > 1) ? $clog2(NUM_A) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_A*WIDTH-1:0] a_in,
  input  logic [SEL_W-1:0]       a_sel,
  input  logic [WIDTH-1:0]       b,
  input  logic                   sel,
  input  logic [2:0]             ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out,
  output logic                   carry,
  output logic                   zero,
  output logic [WIDTH-1:0]       acc
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_sel_q, s1_sel_d;
  logic [2:0]       s1_ctrl_q, s1_ctrl_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s2_free, s1_adv, in_fire;
  logic [WIDTH-1:0] a_mux, b_op, core_res;
  logic             core_carry;

  // Out-of-range selects fall through to channel 0.
  always_comb begin
    a_mux = a_in[WIDTH-1:0];
    for (int k = 1; k < NUM_A; k++) begin
      if (int'(a_sel) == k) a_mux = a_in[k*WIDTH +: WIDTH];
    end
  end

  assign s2_free  = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;

  // acc is read at compute time, so chained sel=1 ops see the previous result.
  assign b_op = s1_sel_q ? acc_q : s1_b_q;

  alu_conv_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a_q),
    .b      (b_op),
    .ctrl   (s1_ctrl_q),
    .result (core_res),
    .carry  (core_carry)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_sel_d    = s1_sel_q;
    s1_ctrl_d   = s1_ctrl_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    acc_d       = acc_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a_mux;
      s1_b_d     = b;
      s1_sel_d   = sel;
      s1_ctrl_d  = ctrl;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      out_valid_d = 1'b1;
      out_d       = core_res;
      carry_d     = core_carry;
      zero_d      = (core_res == '0);
      acc_d       = core_res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_sel_q    <= 1'b0;
      s1_ctrl_q   <= 3'b000;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_sel_q    <= s1_sel_d;
      s1_ctrl_q   <= s1_ctrl_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign acc       = acc_q;

endmodule

// File: doc/alu_conv_pipe.md
Name: alu_conv_pipe

Overview:
Parametrised, pipelined successor to the 8-bit combinational ALU/operand-mux block.
- Selects operand A from NUM_A input channels.
- Selects operand B from the b port or an internal accumulator.
- Executes one of eight ops and returns a registered result with carry/zero flags over valid/ready handshakes.
- Sits between the operand-fetch logic and the result bus of the lab datapath. Throughput is one op per cycle; latency is 2 cycles.

Parameters:
WIDTH, 8, datapath width in bits (>=2).
NUM_A, 2, number of operand-A input channels (>=2).
SEL_W, $clog2(NUM_A), width of a_sel (derived; do not override).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operation request valid
in_ready  out  1  block can accept request this cycle
a_in  in  NUM_A*WIDTH  flattened operand-A channels; channel k = a_in[k*WIDTH +: WIDTH]
a_sel  in  SEL_W  operand-A channel select
b  in  WIDTH  operand B from port
sel  in  1  0: B = b port; 1: B = accumulator
ctrl  in  3  opcode
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out  out  WIDTH  result
carry  out  1  carry/borrow flag
zero  out  1  result == 0
acc  out  WIDTH  current accumulator value (debug)

Behaviour:
- Reset (async, any time, mid-operation included): all pipeline valids=0, out=0, carry=0, zero=0, acc=0, in_ready=1 once rst deasserts. In-flight ops are discarded.
- Stage 1 (S1): on in_valid && in_ready, capture the A operand (mux applied here), b, sel and ctrl. a_sel >= NUM_A selects channel 0.
- Stage 2 (S2/output register): computes from the S1 contents. B = sel ? acc : b_reg, using the acc value at compute time. Back-to-back sel=1 ops therefore chain correctly with no stall.
- Opcodes:
  - 000 ADD A+B, carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - 001 SUB A-B, carry = borrow (A<B).
  - 010 AND; 011 OR; 100 XOR.
  - 101 PASS A.
  - 110 SHL A by B[$clog2(WIDTH)-1:0].
  - 111 SHR logical, same shift amount.
  - Carry=0 for every op except ADD and SUB.
- Flags: zero = (out == 0), registered together with out.
- Accumulator: acc <= result on every S2 capture, whatever sel is.
- Handshake:
  - s2_free = !out_valid || out_ready.
  - S1 advances into S2 when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is a combinational path from out_ready; that path is allowed.
  - out/carry/zero stay stable while out_valid && !out_ready.
  - out_valid drops the cycle after handshake unless a new result is captured in that same cycle.
- Latency: request accepted at edge N -> out_valid=1 after edge N+1, provided no stall.
- Simultaneous events: an output handshake and an S1->S2 move in the same cycle are legal. So is an S1 capture and an S1->S2 move. Results are never lost or duplicated.
- Full condition: with out stalled and S1 occupied, in_ready=0. At most 2 ops are buffered.

Optional Feature:
ALU_CONV_PIPE_SAT_EN
- Defined: ADD clamps to all-ones on carry; SUB clamps to 0 on borrow. The carry flag still reports the raw overflow/borrow. The accumulator stores the clamped value.
- Undefined: ADD and SUB wrap modulo 2^WIDTH.

Decomposition:
- alu_conv_pkg: opcode localparams/enum (OP_ADD..OP_SHR) and the shift-amount width function.
- Sub-module alu_conv_core: purely combinational. Inputs are A, B and ctrl; outputs are result and carry. It contains the SAT logic. alu_conv_pipe instantiates it in S2.

Test Plan:
- Reset: hold rst 3 cycles, then release -> out_valid=0, out=0, acc=0, in_ready=1. Assert rst while 2 ops are in flight -> out_valid=0 and acc=0 immediately.
- ADD: a_sel=1, a_in ch1=0x05, b=0x03, sel=0, ctrl=000, out_ready=1 -> out=0x08, carry=0, zero=0 two edges after acceptance. Then 0xFF+0x01 -> out=0x00, carry=1, zero=1.
- SUB/SAT: 0x00-0x01 -> out=0xFF, carry=1. With ALU_CONV_PIPE_SAT_EN -> out=0x00, carry=1, zero=1.
- Accumulate: after reset, 3 back-to-back ADDs with A=0x10, sel=1 -> outputs 0x10, 0x20, 0x30 on consecutive cycles; acc=0x30.
- Backpressure: out_ready=0, issue 3 ops -> first 2 accepted, in_ready=0 on the third and out held stable. Raise out_ready -> all 3 results delivered in order with no loss.
- Shifts/logic: A=0x81, b=0x03: ctrl=110 -> 0x08; ctrl=111 -> 0x10; ctrl=100 -> 0x82; ctrl=101 -> 0x81. carry=0 in all four cases.
